// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the shift feeder and its downstream shift register.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_feeder_if.sv
// Command handshake plus shift-register drive bundle between a controller (master) and shift_feeder (slave).
interface shift_feeder_if #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             hold;
    logic             shift_left;
    logic             shift_right;
    logic             serial_in;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_dir, cmd_data, cmd_len, hold,
        input  cmd_ready, shift_left, shift_right, serial_in, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_data, cmd_len, hold,
        output cmd_ready, shift_left, shift_right, serial_in, busy, done
    );
endinterface

// File: rtl/shift_register.sv
// WIDTH-bit left/right shift register fed one bit per clock through serial_in; left wins if both enables are high.
module shift_register #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_left,
    input  logic             shift_right,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (shift_left) begin
            data_q <= {data_q[WIDTH-2:0], serial_in};
        end else if (shift_right) begin
            data_q <= {serial_in, data_q[WIDTH-1:1]};
        end
    end

    assign data_out = data_q;
endmodule

// File: rtl/shift_feeder.sv
// Serialises an accepted command word into one shift enable + serial bit per clock, then pulses done.
// Fully registered: first enable the cycle after accept, done one cycle after the last enable; hold stalls SHIFT.
module shift_feeder
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           rst,
    shift_feeder_if.slave bus
);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;

    logic cmd_ready_q;
    logic shift_left_q, shift_left_d;
    logic shift_right_q, shift_right_d;
    logic serial_in_q, serial_in_d;
    logic busy_q;
    logic done_q;

    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] ptr_first;

    function automatic logic bit_at(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] idx);
        return |(d & (ONE_W << idx));
    endfunction

    assign accept    = bus.cmd_valid && cmd_ready_q;
    assign len_eff   = (bus.cmd_len == '0 || bus.cmd_len > LEN_FULL) ? LEN_FULL : bus.cmd_len;
    // Left shifts go MSB-first over the low L bits, right shifts LSB-first.
    assign ptr_first = (bus.cmd_dir == DIR_LEFT) ? (len_eff - LEN_ONE) : '0;

    // cnt_q holds the number of enables still to present after the current one.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        data_d        = data_q;
        dir_d         = dir_q;
        shift_left_d  = 1'b0;
        shift_right_d = 1'b0;
        serial_in_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = SHIFT;
                    data_d        = bus.cmd_data;
                    dir_d         = bus.cmd_dir;
                    cnt_d         = len_eff - LEN_ONE;
                    ptr_d         = ptr_first;
                    shift_left_d  = (bus.cmd_dir == DIR_LEFT);
                    shift_right_d = (bus.cmd_dir == DIR_RIGHT);
                    serial_in_d   = bit_at(bus.cmd_data, ptr_first);
                end
            end
            SHIFT: begin
                if (bus.hold) begin
                    serial_in_d = serial_in_q;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d         = cnt_q - LEN_ONE;
                    ptr_d         = (dir_q == DIR_LEFT) ? (ptr_q - LEN_ONE) : (ptr_q + LEN_ONE);
                    shift_left_d  = (dir_q == DIR_LEFT);
                    shift_right_d = (dir_q == DIR_RIGHT);
                    serial_in_d   = bit_at(data_q, ptr_d);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            data_q        <= '0;
            dir_q         <= DIR_LEFT;
            cmd_ready_q   <= 1'b1;
            shift_left_q  <= 1'b0;
            shift_right_q <= 1'b0;
            serial_in_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            data_q        <= data_d;
            dir_q         <= dir_d;
            cmd_ready_q   <= (state_d == IDLE);
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
            serial_in_q   <= serial_in_d;
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.shift_left  = shift_left_q;
    assign bus.shift_right = shift_right_q;
    assign bus.serial_in   = serial_in_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_shift_feeder.sv
// Drives shift_feeder into shift_register and checks bit order, timing and final contents against a reference model.
module tb_shift_feeder;
    import shift_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int LW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         sr_rst;
    logic [W-1:0] data_out;
    logic [W-1:0] sr_model;
    int           n_checks = 0;
    int           n_fail   = 0;

    shift_feeder_if #(.WIDTH(W), .LEN_W(LW)) bus ();

    shift_feeder #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    shift_register #(.WIDTH(W)) sr (
        .clk         (clk),
        .rst         (sr_rst),
        .shift_left  (bus.shift_left),
        .shift_right (bus.shift_right),
        .serial_in   (bus.serial_in),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.cmd_ready, bus.shift_left, bus.shift_right, bus.serial_in, bus.busy, bus.done};
    endfunction

    function automatic int eff_len(input int len);
        return (len == 0 || len > W) ? W : len;
    endfunction

    // Expected serial stream, first bit presented in bit 0.
    function automatic logic [31:0] exp_seq(input logic [W-1:0] d, input logic dir, input int L);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < L; i++) s[i] = (dir == DIR_LEFT) ? d[L-1-i] : d[i];
        return s;
    endfunction

    // Downstream contents after L bits of d enter from the chosen end.
    function automatic logic [W-1:0] model_after(input logic [W-1:0] prev, input logic [W-1:0] d,
                                                 input logic dir, input int L);
        int full, low, p, r;
        full = (1 << W) - 1;
        low  = int'(d) & ((1 << L) - 1);
        p    = int'(prev);
        if (dir == DIR_LEFT) r = ((p << L) | low) & full;
        else                 r = (p >> L) | (low << (W - L));
        return r[W-1:0];
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        chk("ready_seen", bus.cmd_ready, 1);
    endtask

    // Starts at the negedge of the first cycle after accept; returns at the negedge of the done cycle.
    task automatic collect(input logic dir, input int hold_pct, input int hold_after, input int hold_cycles,
                           output logic [31:0] seq, output int nbits, output int holds, output int done_cyc);
        logic prev_hold, last_si, h;
        int   sched;
        prev_hold = 1'b0;
        last_si   = 1'b0;
        sched     = 0;
        seq       = '0;
        nbits     = 0;
        holds     = 0;
        done_cyc  = -1;
        for (int c = 1; c <= 200; c++) begin
            if (bus.done) begin
                done_cyc = c;
                chk("done_quiet", {bus.shift_left, bus.shift_right, bus.serial_in}, 3'b000);
                chk("done_flags", {bus.busy, bus.cmd_ready}, 2'b10);
                break;
            end
            chk("both_en", bus.shift_left & bus.shift_right, 1'b0);
            chk("shift_flags", {bus.busy, bus.cmd_ready}, 2'b10);
            if (bus.shift_left || bus.shift_right) begin
                chk("en_dir", bus.shift_right, dir);
                if (nbits < 32) seq[nbits] = bus.serial_in;
                nbits++;
            end else if (prev_hold) begin
                chk("hold_si", bus.serial_in, last_si);
            end else begin
                chk("stall_without_hold", prev_hold, 1'b1);
            end
            last_si = bus.serial_in;
            h = ($urandom_range(99) < hold_pct);
            if (hold_after > 0 && nbits >= hold_after && sched < hold_cycles) begin
                h = 1'b1;
                sched++;
            end
            if (h) holds++;
            prev_hold = h;
            bus.hold  = h;
            @(negedge clk);
        end
        bus.hold = 1'b0;
        chk("done_seen", (done_cyc >= 0), 1'b1);
    endtask

    task automatic verify_cmd(input string name, input logic [W-1:0] d, input logic dir, input int L,
                              input logic [31:0] seq, input int nbits, input int holds, input int dc);
        chk({name, "_nbits"}, nbits, L);
        chk({name, "_seq"}, seq, exp_seq(d, dir, L));
        chk({name, "_done_cyc"}, dc, L + holds + 1);
        sr_model = model_after(sr_model, d, dir, L);
        chk({name, "_data_out"}, data_out, sr_model);
    endtask

    task automatic run_cmd(input string name, input logic [W-1:0] d, input logic dir, input int len,
                           input int hold_pct, input int hold_after, input int hold_cycles);
        logic [31:0] seq;
        int          nbits, holds, dc, L;
        L = eff_len(len);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_dir   = dir;
        bus.cmd_len   = LW'(len);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = W'($urandom);
        bus.cmd_dir   = 1'($urandom);
        bus.cmd_len   = LW'($urandom);
        collect(dir, hold_pct, hold_after, hold_cycles, seq, nbits, holds, dc);
        verify_cmd(name, d, dir, L, seq, nbits, holds, dc);
        @(negedge clk);
        chk({name, "_back_idle"}, outs(), 6'b100000);
    endtask

    task automatic clear_downstream();
        sr_rst = 1'b1;
        @(negedge clk);
        sr_rst   = 1'b0;
        sr_model = '0;
    endtask

    initial begin
        logic [31:0] seq;
        int          nbits, holds, dc;
        logic [W-1:0] d;
        logic         dir;
        int           len;

        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        bus.hold      = 1'b0;
        rst           = 1'b1;
        sr_rst        = 1'b1;
        sr_model      = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 6'b100000);
        rst    = 1'b0;
        sr_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", outs(), 6'b100000);
        end

        run_cmd("left_full", 4'b1011, DIR_LEFT, 0, 0, 0, 0);
        chk("left_full_word", data_out, 4'b1011);

        clear_downstream();
        run_cmd("right_part", 4'b0110, DIR_RIGHT, 2, 0, 0, 0);
        chk("right_part_word", data_out, 4'b1000);

        run_cmd("hold_mid", 4'b1100, DIR_LEFT, 4, 0, 2, 3);
        chk("hold_mid_word", data_out, 4'b1100);

        // Back-to-back: valid stays high, second command queued behind the first.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b1001;
        bus.cmd_dir   = DIR_RIGHT;
        bus.cmd_len   = LW'(3);
        @(negedge clk);
        bus.cmd_data  = 4'b0111;
        bus.cmd_dir   = DIR_LEFT;
        bus.cmd_len   = LW'(4);
        collect(DIR_RIGHT, 0, 0, 0, seq, nbits, holds, dc);
        verify_cmd("b2b_a", 4'b1001, DIR_RIGHT, 3, seq, nbits, holds, dc);
        @(negedge clk);
        chk("b2b_ready_after_done", {bus.cmd_ready, bus.busy}, 2'b10);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("b2b_first_en", {bus.shift_left, bus.busy}, 2'b11);
        collect(DIR_LEFT, 0, 0, 0, seq, nbits, holds, dc);
        verify_cmd("b2b_b", 4'b0111, DIR_LEFT, 4, seq, nbits, holds + 1, dc + 1);
        @(negedge clk);

        // Reset during the second shift of a 4-bit command.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b1111;
        bus.cmd_dir   = DIR_LEFT;
        bus.cmd_len   = LW'(4);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_2nd_en", bus.shift_left, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outs", outs(), 6'b100000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_quiet", outs(), 6'b100000);
        end
        clear_downstream();

        for (int i = 0; i < 30; i++) begin
            d   = W'($urandom);
            dir = 1'($urandom);
            len = $urandom_range(0, (1 << LW) - 1);
            run_cmd("rand", d, dir, len, 25, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_feeder.md
Name: shift_feeder

Overview:
- Upstream sequencer for the team's `shift_register` (WIDTH-bit left/right shift with `serial_in`).
- Accepts a parallel word plus a direction command over a valid/ready handshake, then drives `shift_left`/`shift_right` and `serial_in` one bit per clock.
- After `len` shifts the downstream register holds the requested bits; a one-cycle `done` pulse follows.
- Sits between a control FSM or CPU register and the shift register.

Parameters:
- WIDTH, 4, width of the downstream shift register and of `cmd_data`.
- LEN_W, $clog2(WIDTH+1), width of `cmd_len` and of the internal bit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  1  0 = shift left, 1 = shift right.
- cmd_data  in  WIDTH  bits to feed.
- cmd_len  in  LEN_W  number of bits to shift; 0 or >WIDTH means WIDTH.
- hold  in  1  stall: freezes shifting while high.
- shift_left  out  1  to `shift_register.shift_left`.
- shift_right  out  1  to `shift_register.shift_right`.
- serial_in  out  1  to `shift_register.serial_in`.
- busy  out  1  high in SHIFT and DONE states.
- done  out  1  one-cycle pulse after the last shift.

Behaviour:
- All outputs are registered.
- Reset values: `cmd_ready`=1, `shift_left`=0, `shift_right`=0, `serial_in`=0, `busy`=0, `done`=0. State=IDLE, counter=0, data latch=0.
- `rst` dominates every other input on the same edge. Reset mid-SHIFT aborts with no further shift pulses and no `done`.
- Handshake: the command is accepted on an edge where `cmd_valid && cmd_ready` (call it E0). `cmd_data`, `cmd_dir` and effective length L are latched at E0. Inputs are ignored while `cmd_ready`=0.
- State IDLE: `cmd_ready`=1, shift enables 0. On accept -> SHIFT.
- State SHIFT: `cmd_ready`=0, `busy`=1.
  - Each non-held cycle presents exactly one enable (`shift_left` if dir=0, else `shift_right`) with the current bit on `serial_in`.
  - The downstream register samples these at edges E1..EL when `hold` is never asserted.
- Bit order, left shift: MSB-first of the low L bits. Bit L-1 first, bit 0 last. After L=WIDTH, the downstream `data_out` equals `cmd_data`.
- Bit order, right shift: LSB-first. Bit 0 first, bit L-1 last. After L=WIDTH, `data_out` equals `cmd_data`.
- `hold` (sampled each edge in SHIFT):
  - When `hold`=1 at an edge, the next cycle has both enables 0.
  - `serial_in` keeps its value; counter and bit pointer do not advance.
  - Shifting resumes with the same bit once `hold` drops.
  - `hold` is ignored in IDLE and DONE.
- Transition: after the L-th enable has been presented -> DONE.
- State DONE (exactly one cycle): `done`=1, enables 0, `serial_in`=0, `cmd_ready`=0. Then -> IDLE with `cmd_ready`=1.
- Latency with no hold: accept at E0, last enable sampled at EL, `done` high for the cycle sampled at EL+1. Next accept is possible at EL+2.
- Invariants:
  - `shift_left` and `shift_right` are never high together.
  - `serial_in`=0 whenever both enables are 0, except during hold.
- Width rules:
  - The counter counts L down to 0 in LEN_W bits and never wraps.
  - Length clamp: `cmd_len`=0 or `cmd_len`>WIDTH gives L=WIDTH.

Decomposition:
- Shared package `shift_pkg`:
  - constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - the state encoding (IDLE, SHIFT, DONE);
  - the default WIDTH.
- No sub-module; the FSM, counter and bit pointer stay in `shift_feeder`.
- The bench instantiates `shift_feeder` driving `shift_register` to check end-to-end `data_out`.

Test Plan:
- Reset then idle: hold `rst`=1 for 2 cycles -> `cmd_ready`=1, all other outputs 0. Release, no command -> outputs unchanged for 10 cycles.
- Left full word: `cmd_data`=4'b1011, dir=0, len=0 -> `shift_left` high 4 cycles, `serial_in` sequence 1,0,1,1. `done` pulses at EL+1; `data_out`=4'b1011.
- Right partial: downstream preloaded 4'b0000; `cmd_data`=4'b0110, dir=1, len=2 -> `shift_right` high 2 cycles, `serial_in` 0,1. `data_out`=4'b1000; `done` one cycle later.
- Hold mid-stream: left, `cmd_data`=4'b1100, `hold`=1 for 3 cycles after the 2nd bit -> enables low 3 cycles, `serial_in` held. Resume gives sequence 1,1,0,0 and final `data_out`=4'b1100; `done` delayed by 3 cycles.
- Back-to-back and backpressure: `cmd_valid` held high with 2 queued commands -> second accepted exactly 1 cycle after the `done` cycle. No command accepted while `busy`=1; enables never both high.
- Reset mid-operation: assert `rst` during the 2nd shift of a 4-bit command -> next cycle enables 0, no `done`, `cmd_ready`=1.
